// File: rtl/wb_prefetch_buf_if.sv
// Wishbone classic bus bundle.
// Used for both the upstream slave side and the downstream BRAM side.
interface wb_prefetch_buf_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, wdat,
    input  rdat, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, wdat,
    output rdat, ack
  );
endinterface

// File: rtl/wb_prefetch_buf.sv
// Single-line read prefetch buffer in front of a slow BRAM slave.
// Read misses fill one aligned line; writes pass through and merge on hit.
module wb_prefetch_buf #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [7:0]  BASE_HI    = 8'h38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_prefetch_buf_if.slave  wbs,
  wb_prefetch_buf_if.master wbm,
  input  logic              inv_i,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int TW = 30 - OB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [31:0]   r_data [LINE_WORDS];
  logic [TW-1:0] r_tag;
  logic          r_valid;
  logic          r_inv_seen;
  logic [OB-1:0] r_off;
  logic [OB-1:0] r_beat;
  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_mcyc;
  logic          r_mstb;
  logic          r_mwe;
  logic [3:0]    r_msel;
  logic [31:0]   r_madr;
  logic [31:0]   r_mdat;
  logic [15:0]   r_hit;
  logic [15:0]   r_miss;

  logic          w_live;
  logic          w_req;
  logic [OB-1:0] w_off;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic          w_last;
  logic [OB-1:0] w_wr_off;
  logic          w_wr_hit;
  logic [31:0]   w_merged;
  logic          w_unused;

  assign w_live   = wbs.cyc & wbs.stb;
  assign w_req    = w_live & (wbs.adr[31:24] == BASE_HI);
  assign w_off    = wbs.adr[OB+1:2];
  assign w_tag    = wbs.adr[31:OB+2];
  assign w_hit    = r_valid & (w_tag == r_tag) & ~inv_i;
  assign w_last   = (r_beat == OB'(LINE_WORDS - 1));
  assign w_wr_off = r_madr[OB+1:2];
  assign w_wr_hit = r_valid & (r_madr[31:OB+2] == r_tag);
  assign w_unused = &{1'b0, wbs.adr[1:0]};

  // Byte-merge of the pending write into its buffered word.
  always_comb begin
    w_merged = r_data[w_wr_off];
    for (int b = 0; b < 4; b++) begin
      if (r_msel[b]) w_merged[8*b +: 8] = r_mdat[8*b +: 8];
    end
  end

  // Control FSM, line storage and all registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < LINE_WORDS; i++) r_data[i] <= '0;
      r_tag      <= '0;
      r_valid    <= 1'b0;
      r_inv_seen <= 1'b0;
      r_off      <= '0;
      r_beat     <= '0;
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_mcyc     <= 1'b0;
      r_mstb     <= 1'b0;
      r_mwe      <= 1'b0;
      r_msel     <= '0;
      r_madr     <= '0;
      r_mdat     <= '0;
      r_hit      <= '0;
      r_miss     <= '0;
    end else begin
      if (inv_i) r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ack   <= 1'b0;
          r_dat_o <= '0;
          if (w_req && wbs.we) begin
            r_mcyc  <= 1'b1;
            r_mstb  <= 1'b1;
            r_mwe   <= 1'b1;
            r_msel  <= wbs.sel;
            r_madr  <= wbs.adr;
            r_mdat  <= wbs.wdat;
            r_state <= S_WRITE;
          end else if (w_req && w_hit) begin
            r_ack   <= 1'b1;
            r_dat_o <= r_data[w_off];
            r_hit   <= r_hit + 16'd1;
            r_state <= S_RESP;
          end else if (w_req) begin
            r_miss     <= r_miss + 16'd1;
            r_off      <= w_off;
            r_beat     <= '0;
            r_valid    <= 1'b0;
            r_inv_seen <= inv_i;
            r_mcyc     <= 1'b1;
            r_mstb     <= 1'b1;
            r_mwe      <= 1'b0;
            r_msel     <= 4'hF;
            r_madr     <= {w_tag, {(OB+2){1'b0}}};
            r_mdat     <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (inv_i) r_inv_seen <= 1'b1;
          if (r_mstb && wbm.ack) begin
            r_data[r_beat] <= wbm.rdat;
            r_mstb         <= 1'b0;
            if (w_last) begin
              r_mcyc  <= 1'b0;
              r_tag   <= r_madr[31:OB+2];
              r_valid <= ~(r_inv_seen | inv_i);
              r_ack   <= w_live;
              if (!w_live)
                r_dat_o <= '0;
              else if (r_off == r_beat)
                r_dat_o <= wbm.rdat;
              else
                r_dat_o <= r_data[r_off];
              r_state <= S_RESP;
            end else begin
              r_beat <= r_beat + OB'(1);
              r_madr <= r_madr + 32'd4;
            end
          end else if (!r_mstb) begin
            r_mstb <= 1'b1;
          end
        end
        S_WRITE: begin
          if (wbm.ack) begin
            if (w_wr_hit) r_data[w_wr_off] <= w_merged;
            r_mcyc  <= 1'b0;
            r_mstb  <= 1'b0;
            r_mwe   <= 1'b0;
            r_ack   <= w_live;
            r_dat_o <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ack   <= 1'b0;
          r_dat_o <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs.ack  = r_ack;
  assign wbs.rdat = r_dat_o;
  assign wbm.cyc  = r_mcyc;
  assign wbm.stb  = r_mstb;
  assign wbm.we   = r_mwe;
  assign wbm.sel  = r_msel;
  assign wbm.adr  = r_madr;
  assign wbm.wdat = r_mdat;
  assign hit_cnt  = r_hit;
  assign miss_cnt = r_miss;
endmodule

// File: tb/tb_wb_prefetch_buf.sv
// Bench for wb_prefetch_buf: directed scenarios plus random traffic.
// Expected data comes from a word-level memory image and a line model.
module tb_wb_prefetch_buf;
  localparam int LW    = 4;
  localparam int OB    = 2;
  localparam int D     = 10;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inv = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  wb_prefetch_buf_if u_wbs_if ();
  wb_prefetch_buf_if u_wbm_if ();

  wb_prefetch_buf #(
    .LINE_WORDS (LW),
    .BASE_HI    (8'h38)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wbs      (u_wbs_if),
    .wbm      (u_wbm_if),
    .inv_i    (inv),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } ds_t;

  ds_t         ds_q[$];
  logic [31:0] seed;
  logic [31:0] smem [256];
  bit          smem_w [256];
  logic [31:0] exp_mem [256];
  int          s_cnt;
  logic        s_ack;
  logic [31:0] s_dat;
  int          wbm_busy;

  int n_chk = 0;
  int n_fail = 0;
  bit m_valid;
  int unsigned m_tag;
  int m_hit;
  int m_miss;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input int i);
    return smem_w[i] ? smem[i] : init_word(i);
  endfunction

  assign u_wbm_if.ack  = s_ack;
  assign u_wbm_if.rdat = s_dat;

  // Slow BRAM slave: acks D cycles after stb rises, logs each transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
      s_dat <= '0;
    end else if (u_wbm_if.cyc && u_wbm_if.stb && !s_ack) begin
      if (s_cnt == D - 1) begin
        s_ack <= 1'b1;
        s_cnt <= 0;
        ds_q.push_back({u_wbm_if.we, u_wbm_if.sel, u_wbm_if.adr, u_wbm_if.wdat});
        if (u_wbm_if.we) begin
          smem[u_wbm_if.adr[9:2]]   <= merge(mem_rd(int'(u_wbm_if.adr[9:2])),
                                             u_wbm_if.wdat, u_wbm_if.sel);
          smem_w[u_wbm_if.adr[9:2]] <= 1'b1;
        end else begin
          s_dat <= mem_rd(int'(u_wbm_if.adr[9:2]));
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
    end
  end

  // Count cycles with downstream cycle active.
  always @(posedge clk) begin
    if (u_wbm_if.cyc) wbm_busy <= wbm_busy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_req(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input int abort_at, output logic [31:0] rd,
                         output int lat, output bit ok);
    bit done;
    ok = 1'b0;
    rd = '0;
    lat = 0;
    done = 1'b0;
    @(negedge clk);
    u_wbs_if.cyc  = 1'b1;
    u_wbs_if.stb  = 1'b1;
    u_wbs_if.we   = we;
    u_wbs_if.sel  = sel;
    u_wbs_if.adr  = adr;
    u_wbs_if.wdat = dat;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      if (u_wbs_if.ack) begin
        ok = 1'b1;
        rd = u_wbs_if.rdat;
        done = 1'b1;
      end else if (abort_at != 0 && lat == abort_at) begin
        u_wbs_if.cyc = 1'b0;
        u_wbs_if.stb = 1'b0;
      end
    end
    u_wbs_if.cyc = 1'b0;
    u_wbs_if.stb = 1'b0;
    u_wbs_if.we  = 1'b0;
  endtask

  task automatic chk_cnts();
    chk("hit_cnt", 32'(hit_cnt), 32'(m_hit) & 32'hFFFF);
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss) & 32'hFFFF);
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic t_read(input logic [31:0] adr, input bit inv_fill);
    logic [31:0] rd;
    logic [31:0] base;
    int lat;
    int b0;
    bit ok;
    bit hit;
    int unsigned tag;
    tag  = adr >> (OB + 2);
    base = {adr[31:OB+2], {(OB+2){1'b0}}};
    hit  = m_valid && (m_tag == tag);
    b0   = ds_q.size();
    bus_req(1'b0, adr, 4'hF, '0, 0, rd, lat, ok);
    chk("rd_ack", 32'(ok), 32'd1);
    chk("rd_data", rd, exp_mem[adr[9:2]]);
    if (hit) begin
      m_hit++;
      chk("hit_lat", lat, 1);
      chk("hit_ds", ds_q.size() - b0, 0);
    end else begin
      m_miss++;
      // Cycles spanned from the request cycle through the ack cycle.
      chk("miss_span", lat + 1, LW * (D + 2) + 1);
      chk("miss_ds", ds_q.size() - b0, LW);
      for (int k = 0; k < LW; k++) begin
        if (b0 + k < ds_q.size()) begin
          chk("fill_adr", ds_q[b0+k].adr, base + 32'(4 * k));
          chk("fill_we", 32'(ds_q[b0+k].we), 32'd0);
        end
      end
      m_valid = !inv_fill;
      m_tag = tag;
    end
    chk_cnts();
    @(negedge clk);
    chk("dat_idle", u_wbs_if.rdat, '0);
  endtask

  task automatic t_write(input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    logic [31:0] rd;
    int lat;
    int b0;
    bit ok;
    b0 = ds_q.size();
    bus_req(1'b1, adr, sel, dat, 0, rd, lat, ok);
    chk("wr_ack", 32'(ok), 32'd1);
    chk("wr_lat", lat, D + 2);
    chk("wr_dat", rd, '0);
    chk("wr_ds", ds_q.size() - b0, 1);
    if (ds_q.size() > b0) begin
      chk("wr_adr", ds_q[b0].adr, adr);
      chk("wr_sel", 32'(ds_q[b0].sel), 32'(sel));
      chk("wr_wdat", ds_q[b0].dat, dat);
      chk("wr_we", 32'(ds_q[b0].we), 32'd1);
    end
    exp_mem[adr[9:2]] = merge(exp_mem[adr[9:2]], dat, sel);
    chk_cnts();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] adr;
    int lat;
    int b0;
    int busy0;
    bit ok;

    seed = $urandom;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    u_wbs_if.cyc  = 1'b0;
    u_wbs_if.stb  = 1'b0;
    u_wbs_if.we   = 1'b0;
    u_wbs_if.sel  = '0;
    u_wbs_if.adr  = '0;
    u_wbs_if.wdat = '0;
    m_valid = 1'b0;
    m_tag = 0;
    m_hit = 0;
    m_miss = 0;

    #1;
    chk("rst_ack", 32'(u_wbs_if.ack), 32'd0);
    chk("rst_dat", u_wbs_if.rdat, '0);
    chk("rst_mcyc", 32'(u_wbm_if.cyc), 32'd0);
    chk("rst_mstb", 32'(u_wbm_if.stb), 32'd0);
    chk("rst_madr", u_wbm_if.adr, '0);
    chk_cnts();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    t_read(32'h3800_0008, 1'b0);
    t_read(32'h3800_000C, 1'b0);

    t_write(32'h3800_0004, 4'b0011, 32'hA5A5A5A5);
    t_read(32'h3800_0004, 1'b0);

    fork
      t_read(32'h3800_0010, 1'b1);
      begin
        repeat (20) @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
      end
    join
    t_read(32'h3800_0014, 1'b0);

    b0 = ds_q.size();
    bus_req(1'b0, 32'h3800_0020, 4'hF, '0, 5, rd, lat, ok);
    chk("abort_noack", 32'(ok), 32'd0);
    chk("abort_ds", ds_q.size() - b0, LW);
    m_miss++;
    m_valid = 1'b1;
    m_tag = 32'h3800_0020 >> (OB + 2);
    chk_cnts();
    t_read(32'h3800_0024, 1'b0);

    b0 = ds_q.size();
    busy0 = wbm_busy;
    bus_req(1'b0, 32'h3700_0000, 4'hF, '0, 0, rd, lat, ok);
    chk("bad_noack", 32'(ok), 32'd0);
    chk("bad_wbm", wbm_busy - busy0, 0);
    chk("bad_ds", ds_q.size() - b0, 0);
    chk_cnts();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) pulse_inv();
      adr = 32'h3800_0000 | 32'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 2) == 0)
        t_write(adr, 4'($urandom_range(0, 15)), $urandom);
      else
        t_read(adr, 1'b0);
    end

    pulse_inv();
    b0 = ds_q.size();
    fork
      bus_req(1'b0, 32'h3800_0030, 4'hF, '0, 0, rd, lat, ok);
      begin
        for (int i = 0; i < 200 && ds_q.size() <= b0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pre_rst_mcyc", 32'(u_wbm_if.cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        u_wbs_if.cyc = 1'b0;
        u_wbs_if.stb = 1'b0;
        #1;
        chk("async_mcyc", 32'(u_wbm_if.cyc), 32'd0);
        chk("async_mstb", 32'(u_wbm_if.stb), 32'd0);
      end
    join
    chk("rst_noack", 32'(ok), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_hit = 0;
    m_miss = 0;
    chk_cnts();
    t_read(32'h3800_0030, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
